dm_ctrl: RTL and testbench

Data-memory stage for the single-cycle CPU: it consumes the CPU's ALU output as the address, the rt register value as store data and the memory-write strobe, and returns load data the same cycle. It handles word, halfword and byte loads/stores (little-endian, signed/unsigned), a small memory-mapped I/O window (free-running cycle counter, LED register, status register), sticky misalignment detection, and a debug read port for the simulator.

---
 rtl/dm_ctrl_if.sv | 22 ++
 rtl/dm_ctrl.sv | 126 ++++++++++++
 tb/tb_dm_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/dm_ctrl_if.sv
// CPU-side data-memory bus plus debug read port for dm_ctrl.
interface dm_ctrl_if;
    logic        DMWr;
    logic [31:0] addr;
    logic [31:0] din;
    logic [2:0]  DMType;
    logic [31:0] dout;
    logic        misalign;
    logic [15:0] led;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    modport master (
        output DMWr, addr, din, DMType, dbg_addr,
        input  dout, misalign, led, dbg_data
    );

    modport slave (
        input  DMWr, addr, din, DMType, dbg_addr,
        output dout, misalign, led, dbg_data
    );
endinterface

// File: rtl/dm_ctrl.sv
// Data-memory stage: RAM with byte/half/word access, MMIO (CYCLE, LED, STATUS),
// sticky misalignment flag and a combinational debug read port.
module dm_ctrl #(
    parameter int unsigned DEPTH_WORDS = 128
) (
    input  logic      clk,
    input  logic      rst,
    dm_ctrl_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    localparam logic [31:0] ADDR_CYCLE  = 32'h0000_7F00;
    localparam logic [31:0] ADDR_LED    = 32'h0000_7F04;
    localparam logic [31:0] ADDR_STATUS = 32'h0000_7F08;

    localparam logic [2:0] T_HALF_S = 3'b001;
    localparam logic [2:0] T_HALF_U = 3'b010;
    localparam logic [2:0] T_BYTE_S = 3'b011;
    localparam logic [2:0] T_BYTE_U = 3'b100;

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] cycle_q, cycle_d;
    logic [15:0] led_q, led_d;
    logic        misalign_q, misalign_d;

    logic             is_half, is_byte, is_word, is_signed;
    logic             mis_c, in_ram_c, ram_we_c;
    logic             sel_cycle, sel_led, sel_status;
    logic [IDX_W-1:0] widx_c, dbg_idx_c;
    logic [31:0]      rd_word_c, wr_word_c, load_c, dout_c;
    logic [15:0]      half_c;
    logic [7:0]       byte_c;

    // Access decode and address-map selection
    always_comb begin
        is_half    = (bus.DMType == T_HALF_S) || (bus.DMType == T_HALF_U);
        is_byte    = (bus.DMType == T_BYTE_S) || (bus.DMType == T_BYTE_U);
        is_word    = !is_half && !is_byte;
        is_signed  = (bus.DMType == T_HALF_S) || (bus.DMType == T_BYTE_S);
        mis_c      = (is_word && (bus.addr[1:0] != 2'b00)) || (is_half && bus.addr[0]);
        in_ram_c   = (bus.addr[31:IDX_W+2] == '0);
        widx_c     = bus.addr[IDX_W+1:2];
        dbg_idx_c  = IDX_W'(bus.dbg_addr);
        sel_cycle  = (bus.addr == ADDR_CYCLE);
        sel_led    = (bus.addr == ADDR_LED);
        sel_status = (bus.addr == ADDR_STATUS);
    end

    // Load path: lane extraction and extension
    always_comb begin
        rd_word_c = mem_q[widx_c];
        half_c    = bus.addr[1] ? rd_word_c[31:16] : rd_word_c[15:0];
        byte_c    = rd_word_c[{bus.addr[1:0], 3'b000} +: 8];
        load_c    = rd_word_c;
        if (is_half) begin
            load_c = {{16{is_signed & half_c[15]}}, half_c};
        end else if (is_byte) begin
            load_c = {{24{is_signed & byte_c[7]}}, byte_c};
        end

        dout_c = '0;
        if (mis_c) begin
            dout_c = '0;
        end else if (in_ram_c) begin
            dout_c = load_c;
        end else if (sel_cycle) begin
            dout_c = cycle_q;
        end else if (sel_led) begin
            dout_c = {16'h0000, led_q};
        end else if (sel_status) begin
            dout_c = {31'd0, misalign_q};
        end
    end

    // Store path: merge the addressed lane(s) into the current word
    always_comb begin
        wr_word_c = rd_word_c;
        if (is_byte) begin
            wr_word_c[{bus.addr[1:0], 3'b000} +: 8] = bus.din[7:0];
        end else if (is_half) begin
            wr_word_c[{bus.addr[1], 4'b0000} +: 16] = bus.din[15:0];
        end else begin
            wr_word_c = bus.din;
        end
        ram_we_c = bus.DMWr && in_ram_c && !mis_c;
    end

    // Next-state for counter, LED and sticky misalign
    always_comb begin
        cycle_d    = cycle_q + 32'd1;
        led_d      = led_q;
        misalign_d = misalign_q;
        if (bus.DMWr && is_word && sel_led) begin
            led_d = bus.din[15:0];
        end
        if (mis_c) begin
            misalign_d = 1'b1;
        end else if (bus.DMWr && is_word && sel_status) begin
            misalign_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q    <= '0;
            led_q      <= '0;
            misalign_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cycle_q    <= cycle_d;
            led_q      <= led_d;
            misalign_q <= misalign_d;
            if (ram_we_c) begin
                mem_q[widx_c] <= wr_word_c;
            end
        end
    end

    assign bus.dout     = dout_c;
    assign bus.dbg_data = mem_q[dbg_idx_c];
    assign bus.led      = led_q;
    assign bus.misalign = misalign_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// Self-checking bench for dm_ctrl: vector table with a dout scoreboard,
// plus hand sequences for counter, wrap and asynchronous reset.
module tb_dm_ctrl;
    logic clk;
    logic rst;

    dm_ctrl_if bus ();

    dm_ctrl #(.DEPTH_WORDS(128)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] exp_dout;
        logic        exp_mis;
        logic [15:0] exp_led;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic [2:0] typ, input logic [31:0] a,
                         input logic [31:0] d);
        bus.DMWr   = wr;
        bus.DMType = typ;
        bus.addr   = a;
        bus.din    = d;
    endtask

    function automatic vec_t mk(input logic wr, input logic [2:0] typ, input logic [31:0] a,
                                input logic [31:0] d, input logic [31:0] ed,
                                input logic em, input logic [15:0] el);
        vec_t v;
        v.wr = wr; v.typ = typ; v.addr = a; v.din = d;
        v.exp_dout = ed; v.exp_mis = em; v.exp_led = el;
        return v;
    endfunction

    logic [31:0] v1, v2, pop_v;

    initial begin
        // wr, type, addr, din, dout during the cycle, misalign and led after the edge
        vecs.push_back(mk(1, 3'd0, 32'h10,   32'h1234_5678, 32'h0000_0000, 0, 16'h0000));
        vecs.push_back(mk(0, 3'd0, 32'h10,   32'h0,         32'h1234_5678, 0, 16'h0000));
        vecs.push_back(mk(1, 3'd3, 32'h11,   32'hFFFF_FFAB, 32'h0000_0056, 0, 16'h0000));
        vecs.push_back(mk(0, 3'd0, 32'h10,   32'h0,         32'h1234_AB78, 0, 16'h0000));
        vecs.push_back(mk(0, 3'd3, 32'h11,   32'h0,         32'hFFFF_FFAB, 0, 16'h0000));
        vecs.push_back(mk(0, 3'd4, 32'h11,   32'h0,         32'h0000_00AB, 0, 16'h0000));
        vecs.push_back(mk(0, 3'd1, 32'h12,   32'h0,         32'h0000_1234, 0, 16'h0000));
        vecs.push_back(mk(1, 3'd2, 32'h12,   32'hFFFF_8001, 32'h0000_1234, 0, 16'h0000));
        vecs.push_back(mk(0, 3'd1, 32'h12,   32'h0,         32'hFFFF_8001, 0, 16'h0000));
        vecs.push_back(mk(0, 3'd2, 32'h12,   32'h0,         32'h0000_8001, 0, 16'h0000));
        vecs.push_back(mk(0, 3'd0, 32'h10,   32'h0,         32'h8001_AB78, 0, 16'h0000));
        vecs.push_back(mk(0, 3'd0, 32'h13,   32'h0,         32'h0000_0000, 1, 16'h0000));
        vecs.push_back(mk(1, 3'd1, 32'h11,   32'h5555_5555, 32'h0000_0000, 1, 16'h0000));
        vecs.push_back(mk(0, 3'd0, 32'h10,   32'h0,         32'h8001_AB78, 1, 16'h0000));
        vecs.push_back(mk(0, 3'd0, 32'h7F08, 32'h0,         32'h0000_0001, 1, 16'h0000));
        vecs.push_back(mk(1, 3'd0, 32'h7F08, 32'h1234_0000, 32'h0000_0001, 0, 16'h0000));
        vecs.push_back(mk(0, 3'd0, 32'h7F08, 32'h0,         32'h0000_0000, 0, 16'h0000));
        vecs.push_back(mk(1, 3'd0, 32'h7F04, 32'hDEAD_BEEF, 32'h0000_0000, 0, 16'hBEEF));
        vecs.push_back(mk(0, 3'd0, 32'h7F04, 32'h0,         32'h0000_BEEF, 0, 16'hBEEF));
        vecs.push_back(mk(1, 3'd3, 32'h7F04, 32'h0000_0011, 32'h0000_BEEF, 0, 16'hBEEF));
        vecs.push_back(mk(0, 3'd3, 32'h7F04, 32'h0,         32'h0000_BEEF, 0, 16'hBEEF));
        vecs.push_back(mk(0, 3'd0, 32'h7F0C, 32'h0,         32'h0000_0000, 0, 16'hBEEF));
        vecs.push_back(mk(1, 3'd0, 32'h7F0C, 32'h0000_0099, 32'h0000_0000, 0, 16'hBEEF));
        vecs.push_back(mk(1, 3'd0, 32'h200,  32'h0000_0077, 32'h0000_0000, 0, 16'hBEEF));
        vecs.push_back(mk(0, 3'd0, 32'h0,    32'h0,         32'h0000_0000, 0, 16'hBEEF));
        vecs.push_back(mk(0, 3'd4, 32'h13,   32'h0,         32'h0000_0080, 0, 16'hBEEF));
        vecs.push_back(mk(0, 3'd3, 32'h13,   32'h0,         32'hFFFF_FF80, 0, 16'hBEEF));
        vecs.push_back(mk(0, 3'd5, 32'h10,   32'h0,         32'h8001_AB78, 0, 16'hBEEF));
        vecs.push_back(mk(0, 3'd1, 32'h11,   32'h0,         32'h0000_0000, 1, 16'hBEEF));
        vecs.push_back(mk(0, 3'd7, 32'h12,   32'h0,         32'h0000_0000, 1, 16'hBEEF));
        vecs.push_back(mk(1, 3'd2, 32'h7F08, 32'h0,         32'h0000_0001, 1, 16'hBEEF));
        vecs.push_back(mk(1, 3'd0, 32'h7F08, 32'h0,         32'h0000_0001, 0, 16'hBEEF));

        rst = 1'b1;
        drive(1'b0, 3'd0, 32'h0, 32'h0);
        bus.dbg_addr = 5'd0;
        #1;
        check("reset dout", bus.dout, 32'h0);
        check("reset led", {16'h0, bus.led}, 32'h0);
        check("reset misalign", {31'd0, bus.misalign}, 32'h0);
        check("reset dbg_data", bus.dbg_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].wr, vecs[i].typ, vecs[i].addr, vecs[i].din);
            exp_q.push_back(vecs[i].exp_dout);
            #1;
            pop_v = exp_q.pop_front();
            check($sformatf("vec%0d dout", i), bus.dout, pop_v);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d misalign", i), {31'd0, bus.misalign}, {31'd0, vecs[i].exp_mis});
            check($sformatf("vec%0d led", i), {16'h0, bus.led}, {16'h0, vecs[i].exp_led});
        end

        // Debug port
        @(negedge clk);
        drive(1'b0, 3'd0, 32'h0, 32'h0);
        bus.dbg_addr = 5'd4;
        #1;
        check("dbg word4", bus.dbg_data, 32'h8001_AB78);
        bus.dbg_addr = 5'd1;
        #1;
        check("dbg word1", bus.dbg_data, 32'h0);

        // Two CYCLE reads seven edges apart
        @(negedge clk);
        drive(1'b0, 3'd0, 32'h7F00, 32'h0);
        #1;
        v1 = bus.dout;
        repeat (7) @(posedge clk);
        @(negedge clk);
        #1;
        v2 = bus.dout;
        check("cycle delta", v2 - v1, 32'd7);

        // Counter wrap from all-ones
        @(negedge clk);
        force dut.cycle_q = 32'hFFFF_FFFF;
        #1;
        check("cycle preset", bus.dout, 32'hFFFF_FFFF);
        release dut.cycle_q;
        @(posedge clk);
        #1;
        check("cycle wrap", bus.dout, 32'h0);
        @(posedge clk);
        #1;
        check("cycle after wrap", bus.dout, 32'h1);

        // Asynchronous reset between edges
        @(negedge clk);
        drive(1'b0, 3'd0, 32'h13, 32'h0);
        @(posedge clk);
        #1;
        check("pre-reset misalign", {31'd0, bus.misalign}, 32'h1);
        drive(1'b0, 3'd0, 32'h10, 32'h0);
        bus.dbg_addr = 5'd4;
        #2;
        rst = 1'b1;
        #1;
        check("async led", {16'h0, bus.led}, 32'h0);
        check("async misalign", {31'd0, bus.misalign}, 32'h0);
        check("async dbg_data", bus.dbg_data, 32'h0);
        check("async lw 0x10", bus.dout, 32'h0);
        drive(1'b1, 3'd0, 32'h10, 32'hCAFE_F00D);
        @(posedge clk);
        #1;
        check("store during reset", bus.dbg_data, 32'h0);
        drive(1'b0, 3'd0, 32'h7F00, 32'h0);
        #1;
        check("cycle held in reset", bus.dout, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("cycle first edge", bus.dout, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
